planificador_paralelo_serial: RTL and testbench

//  Sequencer and arbiter in front of the 9-bit paralelo -> 2-bit serial converter.
//  - Shares the single serializer lane among N_REQ packet sources.
//  - After reset, runs a COM synchronisation preamble.
//  - In steady state, periodically inserts COM words for lock maintenance.
//  - Drives paralelo = {valid, data[7:0]}, one word per clk4f cycle (the serializer consumes one word per clk4f).

---
 rtl/planificador_paralelo_serial_pkg.sv | 22 ++
 rtl/planificador_paralelo_serial_selector_rr.sv | 49 ++++
 rtl/planificador_paralelo_serial.sv | 185 ++++++++++++++++++
 tb/tb_planificador_paralelo_serial.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/planificador_paralelo_serial_pkg.sv
// Shared definitions for the paralelo -> serial lane scheduler: state encodings,
// comma/idle word and word formatting helper.
package planificador_paralelo_serial_pkg;

    localparam int WORD_W = 9;
    localparam int IDX_W  = 3;

    localparam logic [7:0]        COM       = 8'hBC;
    localparam logic [WORD_W-1:0] IDLE_WORD = {1'b0, COM};

    typedef enum logic [1:0] {
        INICIO = 2'b00,
        SYNC   = 2'b01,
        ACTIVO = 2'b10,
        PAUSA  = 2'b11
    } estado_t;

    function automatic logic [WORD_W-1:0] palabra_valida(input logic [7:0] dato);
        return {1'b1, dato};
    endfunction

endpackage

// File: rtl/planificador_paralelo_serial_selector_rr.sv
// Combinational round-robin picker: lowest valid index at or after ptr_i, wrapping.
// The request vector is rotated so the scan always runs over constant indices.
module planificador_paralelo_serial_selector_rr
    import planificador_paralelo_serial_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [2*N_REQ-1:0] valid_dbl_s;
    logic [2*N_REQ-1:0] grant_dbl_s;
    logic [N_REQ-1:0]   valid_rot_s;
    logic [N_REQ-1:0]   grant_rot_s;
    logic               found_s;
    logic               hit_s;

    // Rotate requests so that bit 0 corresponds to the pointer position.
    always_comb begin
        valid_dbl_s = {req_valid_i, req_valid_i} >> ptr_i;
        valid_rot_s = valid_dbl_s[N_REQ-1:0];
    end

    // First-set scan over the rotated vector; hits map back to (ptr+k) mod N_REQ.
    always_comb begin
        grant_rot_s = '0;
        idx_o       = '0;
        found_s     = 1'b0;
        hit_s       = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            hit_s          = !found_s && valid_rot_s[k];
            grant_rot_s[k] = hit_s;
            idx_o          = hit_s ? IDX_W'((int'(ptr_i) + k) % N_REQ) : idx_o;
            found_s        = found_s | hit_s;
        end
        any_o = found_s;
    end

    // Rotate the one-hot grant back into requester order.
    always_comb begin
        grant_dbl_s = {grant_rot_s, grant_rot_s} << ptr_i;
        grant_o     = grant_dbl_s[2*N_REQ-1:N_REQ];
    end

endmodule

// File: rtl/planificador_paralelo_serial.sv
// Sequencer/arbiter sharing one serializer lane among N_REQ packet sources, with
// a COM preamble after reset or pause and periodic COM insertion while active.
module planificador_paralelo_serial
    import planificador_paralelo_serial_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int N_SYNC = 4,
    parameter int P_COM  = 64
) (
    input  logic                 clk4f,
    input  logic                 reset_L,
    input  logic                 habilitar,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [WORD_W-1:0]    paralelo,
    output logic [IDX_W-1:0]     grant_id,
    output logic [1:0]           estado,
    output logic                 sync_listo
);

    localparam int               CW       = $clog2(P_COM);
    localparam logic [CW-1:0]    COM_ULT  = CW'(P_COM - 1);
    localparam logic [3:0]       SYNC_ULT = 4'(N_SYNC - 1);

    estado_t             estado_q,    estado_d;
    logic [3:0]          sync_cnt_q,  sync_cnt_d;
    logic [CW-1:0]       com_cnt_q,   com_cnt_d;
    logic [IDX_W-1:0]    ptr_q,       ptr_d;
    logic [IDX_W-1:0]    owner_q,     owner_d;
    logic                owner_vld_q, owner_vld_d;
    logic [IDX_W-1:0]    grant_q,     grant_d;
    logic [WORD_W-1:0]   paralelo_q,  paralelo_d;

    logic [N_REQ-1:0]    sel_grant_s;
    logic [IDX_W-1:0]    sel_idx_s;
    logic                sel_any_s;
    logic                force_com_s;
    logic [N_REQ-1:0]    owner_oh_s;
    logic [N_REQ-1:0]    ready_s;
    logic [N_REQ-1:0]    acc_oh_s;
    logic                accept_s;
    logic [IDX_W-1:0]    acc_idx_s;
    logic                acc_last_s;
    logic [7:0]          acc_data_s;

    planificador_paralelo_serial_selector_rr #(
        .N_REQ (N_REQ)
    ) u_selector_rr (
        .req_valid_i (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (sel_grant_s),
        .idx_o       (sel_idx_s),
        .any_o       (sel_any_s)
    );

    // The maintenance COM slot outranks any acceptance in that cycle.
    assign force_com_s = (estado_q == ACTIVO) && (com_cnt_q == COM_ULT);

    // Current owner as a one-hot mask.
    always_comb begin
        owner_oh_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            owner_oh_s[i] = (owner_q == IDX_W'(i));
        end
    end

    // Ready: owner only while a packet is in flight; new grants need habilitar.
    always_comb begin
        ready_s = '0;
        if ((estado_q == ACTIVO) && !force_com_s) begin
            if (owner_vld_q) begin
                ready_s = owner_oh_s & req_valid;
            end else if (habilitar && sel_any_s) begin
                ready_s = sel_grant_s;
            end else begin
                ready_s = '0;
            end
        end else begin
            ready_s = '0;
        end
    end

    // Decode the accepted word (at most one ready bit is ever set).
    always_comb begin
        acc_oh_s   = ready_s & req_valid;
        accept_s   = |acc_oh_s;
        acc_idx_s  = '0;
        acc_last_s = 1'b0;
        acc_data_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            acc_idx_s  = acc_oh_s[i] ? IDX_W'(i) : acc_idx_s;
            acc_last_s = acc_last_s | (acc_oh_s[i] & req_last[i]);
            acc_data_s = acc_data_s | ({8{acc_oh_s[i]}} & req_data[8*i +: 8]);
        end
    end

    // Next-state: ownership/pointer bookkeeping, output word and FSM.
    always_comb begin
        estado_d    = estado_q;
        sync_cnt_d  = '0;
        com_cnt_d   = '0;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        grant_d     = grant_q;
        paralelo_d  = IDLE_WORD;

        if (accept_s) begin
            paralelo_d = palabra_valida(acc_data_s);
            grant_d    = acc_idx_s;
            if (acc_last_s) begin
                owner_vld_d = 1'b0;
                ptr_d       = (acc_idx_s == IDX_W'(N_REQ - 1)) ? '0 : acc_idx_s + IDX_W'(1);
            end else begin
                owner_vld_d = 1'b1;
                owner_d     = acc_idx_s;
            end
        end else begin
            paralelo_d = IDLE_WORD;
        end

        case (estado_q)
            INICIO: begin
                estado_d = SYNC;
            end
            SYNC: begin
                if (sync_cnt_q == SYNC_ULT) begin
                    estado_d = ACTIVO;
                end else begin
                    sync_cnt_d = sync_cnt_q + 4'd1;
                end
            end
            ACTIVO: begin
                // Pause only at a packet boundary, including the one created by this cycle's last word.
                if (!habilitar && !owner_vld_d) begin
                    estado_d = PAUSA;
                end else begin
                    com_cnt_d = force_com_s ? '0 : com_cnt_q + CW'(1);
                end
            end
            PAUSA: begin
                if (habilitar) begin
                    estado_d = SYNC;
                end else begin
                    estado_d = PAUSA;
                end
            end
            default: begin
                estado_d = INICIO;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk4f or negedge reset_L) begin
        if (!reset_L) begin
            estado_q    <= INICIO;
            sync_cnt_q  <= '0;
            com_cnt_q   <= '0;
            ptr_q       <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            grant_q     <= '0;
            paralelo_q  <= IDLE_WORD;
        end else begin
            estado_q    <= estado_d;
            sync_cnt_q  <= sync_cnt_d;
            com_cnt_q   <= com_cnt_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            grant_q     <= grant_d;
            paralelo_q  <= paralelo_d;
        end
    end

    assign req_ready  = ready_s;
    assign paralelo   = paralelo_q;
    assign grant_id   = grant_q;
    assign estado     = estado_q;
    assign sync_listo = (estado_q == ACTIVO);

endmodule

// File: tb/tb_planificador_paralelo_serial.sv
// Scoreboard bench for planificador_paralelo_serial: expected words are queued in
// arbitration order when stimulus is loaded and popped as valid words leave the DUT.
module tb_planificador_paralelo_serial;

    localparam int N = 4;

    logic             clk4f = 1'b0;
    logic             reset_L;
    logic             habilitar;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic [8:0]       paralelo;
    logic [2:0]       grant_id;
    logic [1:0]       estado;
    logic             sync_listo;

    int checks = 0;
    int errors = 0;
    int tick_n = 0;

    logic [8:0] src_q [N][$];
    logic [8:0] sb_q [$];
    logic [N-1:0] hs_pend;
    bit         t4_mon = 1'b0;
    int         gaps [$];

    always #5 clk4f = ~clk4f;

    planificador_paralelo_serial #(
        .N_REQ  (4),
        .N_SYNC (4),
        .P_COM  (64)
    ) dut (
        .clk4f      (clk4f),
        .reset_L    (reset_L),
        .habilitar  (habilitar),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .paralelo   (paralelo),
        .grant_id   (grant_id),
        .estado     (estado),
        .sync_listo (sync_listo)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=0x%0h exp=0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_sources();
        logic [8:0] w;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                w = src_q[i][0];
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = w[7:0];
                req_last[i]       = w[8];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    endtask

    // Present loaded words and capture which of them will be taken at the next edge.
    task automatic load_done();
        drive_sources();
        #1;
        hs_pend = req_valid & req_ready;
    endtask

    task automatic set_hab(input logic v);
        habilitar = v;
        #1;
        hs_pend = req_valid & req_ready;
    endtask

    task automatic push_word(input int id, input logic last, input logic [7:0] d);
        src_q[id].push_back({last, d});
        sb_q.push_back({1'b1, d});
    endtask

    // One clock: retire handshaken words, re-drive, then check the output at negedge.
    task automatic tick();
        logic [8:0] exp_w;
        @(posedge clk4f);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_pend[i]) void'(src_q[i].pop_front());
        end
        drive_sources();
        @(negedge clk4f);
        tick_n++;
        if (paralelo[8]) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_word", 32'(paralelo), 32'h0BC);
            end else begin
                exp_w = sb_q.pop_front();
                check_eq("word", 32'(paralelo), 32'(exp_w));
            end
        end else begin
            check_eq("idle_word", 32'(paralelo), 32'h0BC);
        end
        check_eq("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        if (t4_mon && req_valid[2] && !req_ready[2]) gaps.push_back(tick_n);
        hs_pend = req_valid & req_ready;
    endtask

    task automatic run_until_drained(input string tag, input int limit);
        int n = 0;
        while (sb_q.size() > 0 && n < limit) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(sb_q.size()), 32'd0);
    endtask

    // Preamble: optional INICIO cycle, four SYNC cycles with no grants, then ACTIVO.
    task automatic check_preamble(input bit from_reset);
        if (from_reset) begin
            check_eq("pre_inicio", 32'(estado), 32'd0);
            check_eq("pre_inicio_ready", 32'(req_ready), 32'd0);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            check_eq("pre_sync", 32'(estado), 32'd1);
            check_eq("pre_sync_ready", 32'(req_ready), 32'd0);
            check_eq("pre_sync_listo", 32'(sync_listo), 32'd0);
            tick();
        end
        check_eq("pre_activo", 32'(estado), 32'd2);
        check_eq("pre_activo_listo", 32'(sync_listo), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        reset_L   = 1'b1;
        habilitar = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        hs_pend   = '0;
        #1 reset_L = 1'b0;
        #1;
        check_eq("rst_paralelo", 32'(paralelo), 32'h0BC);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_grant", 32'(grant_id), 32'd0);
        check_eq("rst_estado", 32'(estado), 32'd0);
        check_eq("rst_listo", 32'(sync_listo), 32'd0);

        // 1: preamble with no requests, then idle ACTIVO
        repeat (2) @(negedge clk4f);
        reset_L = 1'b1;
        check_preamble(1'b1);
        repeat (5) tick();
        check_eq("t1_activo", 32'(estado), 32'd2);

        // 2: req0 three-word packet while req1 waits
        push_word(0, 1'b0, 8'hA1);
        push_word(0, 1'b0, 8'hA2);
        push_word(0, 1'b1, 8'hA3);
        push_word(1, 1'b1, 8'hB1);
        load_done();
        run_until_drained("t2_drained", 20);
        check_eq("t2_grant", 32'(grant_id), 32'd1);

        // 3: everyone streams single-word packets; pointer now at 2
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                push_word((2 + k) % 4, 1'b1, 8'(8'h40 + 16 * ((2 + k) % 4) + r));
            end
        end
        load_done();
        run_until_drained("t3_drained", 30);
        check_eq("t3_grant", 32'(grant_id), 32'd1);

        // 4: long packet from req2 with req3 waiting; maintenance COM every 64 cycles
        for (int k = 0; k < 150; k++) push_word(2, (k == 149), 8'(k));
        push_word(3, 1'b1, 8'h5A);
        gaps.delete();
        t4_mon = 1'b1;
        load_done();
        run_until_drained("t4_drained", 400);
        t4_mon = 1'b0;
        check_eq("t4_gap_count", 32'(gaps.size() >= 2), 32'd1);
        for (int k = 1; k < gaps.size(); k++) begin
            check_eq("t4_gap_period", 32'(gaps[k] - gaps[k-1]), 32'd64);
        end
        check_eq("t4_grant", 32'(grant_id), 32'd3);

        // 5: habilitar drops mid-packet; packet completes, then PAUSA and a fresh preamble
        push_word(0, 1'b0, 8'hD1);
        push_word(0, 1'b0, 8'hD2);
        push_word(0, 1'b1, 8'hD3);
        push_word(1, 1'b1, 8'hE1);
        load_done();
        n = 0;
        while (sb_q.size() > 3 && n < 10) begin tick(); n++; end
        set_hab(1'b0);
        n = 0;
        while (sb_q.size() > 1 && n < 10) begin tick(); n++; end
        check_eq("t5_d3_sent", 32'(sb_q.size()), 32'd1);
        check_eq("t5_pausa", 32'(estado), 32'd3);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("t5_pausa_hold", 32'(estado), 32'd3);
            check_eq("t5_pausa_ready", 32'(req_ready), 32'd0);
        end
        set_hab(1'b1);
        check_preamble(1'b0);
        run_until_drained("t5_drained", 10);
        check_eq("t5_grant", 32'(grant_id), 32'd1);

        // 6: asynchronous reset mid-packet
        push_word(0, 1'b0, 8'hF1);
        push_word(0, 1'b0, 8'hF2);
        push_word(0, 1'b0, 8'hF3);
        push_word(0, 1'b1, 8'hF4);
        load_done();
        n = 0;
        while (sb_q.size() > 2 && n < 10) begin tick(); n++; end
        #3 reset_L = 1'b0;
        #1;
        check_eq("t6_paralelo", 32'(paralelo), 32'h0BC);
        check_eq("t6_ready", 32'(req_ready), 32'd0);
        check_eq("t6_estado", 32'(estado), 32'd0);
        check_eq("t6_listo", 32'(sync_listo), 32'd0);
        check_eq("t6_grant", 32'(grant_id), 32'd0);
        for (int i = 0; i < N; i++) src_q[i].delete();
        sb_q.delete();
        push_word(1, 1'b1, 8'h66);
        drive_sources();
        hs_pend = '0;
        repeat (2) @(negedge clk4f);
        reset_L = 1'b1;
        check_preamble(1'b1);
        run_until_drained("t6_drained", 10);
        check_eq("t6_grant_after", 32'(grant_id), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
